// File: rtl/irc_pkg.sv
// Shared types and constants for the parametrised IR serial transmitter.
package irc_pkg;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } irc_state_e;

  // Parity mode codes; code 3 also means no parity.
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // Legal range of the data-bit count.
  localparam int unsigned DATA_BITS_MIN = 5;
  localparam int unsigned DATA_BITS_MAX = 9;

  // True when the mode inserts a parity bit.
  function automatic logic parity_en(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/axis_irc_tx_gen_if.sv
// AXI4-Stream byte channel feeding the IR transmitter.
interface axis_irc_tx_gen_if #(
  parameter int unsigned C_DATA_BIT = 8
);

  logic [C_DATA_BIT-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/irc_tick_gen.sv
// Reloadable clock divider: one-cycle tick every max(div,1) cycles, synchronous clear.
module irc_tick_gen #(
  parameter int unsigned C_DIV_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic [C_DIV_W-1:0] div_i,
  output logic               tick_o
);

  localparam logic [C_DIV_W-1:0] DivOne = C_DIV_W'(1);

  logic [C_DIV_W-1:0] cnt_q, cnt_d, div_m1;

  // Terminal count; '>=' recovers cleanly if the divisor shrinks below the count.
  always_comb begin
    div_m1 = (div_i == '0) ? '0 : (div_i - DivOne);
    tick_o = (cnt_q >= div_m1);
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DivOne;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axis_irc_tx_gen.sv
// IR serial transmitter: AXI4-Stream payload in, raw and carrier-modulated serial line out.
module axis_irc_tx_gen
  import irc_pkg::*;
#(
  parameter int unsigned C_DATA_BIT   = 8,
  parameter int unsigned C_OVERSAMPLE = 16,
  parameter int unsigned C_DIV_W      = 16
) (
  input  logic               aclk,
  input  logic               aresetn,
  axis_irc_tx_gen_if.slave   s_axis,
  input  logic [C_DIV_W-1:0] cfg_baud_div,
  input  logic [3:0]         cfg_data_bits,
  input  logic [1:0]         cfg_parity,
  input  logic               cfg_stop2,
  input  logic               cfg_carrier_en,
  input  logic [C_DIV_W-1:0] cfg_carrier_div,
  output logic               busy,
  output logic               tx_line,
  output logic               tx_mod
);

  localparam int unsigned     OvsW    = $clog2(C_OVERSAMPLE);
  localparam logic [OvsW-1:0] OvsLast = OvsW'(C_OVERSAMPLE - 1);
  localparam logic [OvsW-1:0] OvsOne  = OvsW'(1);
  localparam logic [3:0]      BitsMax = 4'(C_DATA_BIT);
  localparam logic [3:0]      BitsMin = 4'(DATA_BITS_MIN);

  irc_state_e            state_q;
  logic [C_DATA_BIT-1:0] shreg_q;
  logic [3:0]            bits_q, bit_idx_q, bits_eff;
  logic [1:0]            par_mode_q;
  logic                  par_acc_q, stop2_q, stop_idx_q, car_en_q;
  logic [C_DIV_W-1:0]    baud_div_q;
  logic [OvsW-1:0]       ovs_q;
  logic                  tx_line_q, carrier_q;
  logic                  idle, hs, baud_tick, car_tick, bit_end;

  assign idle      = (state_q == StIdle);
  assign hs        = idle && s_axis.tvalid;
  assign bit_end   = !idle && baud_tick && (ovs_q == OvsLast);
  assign bits_eff  = ((cfg_data_bits >= BitsMin) && (cfg_data_bits <= BitsMax)) ?
                     cfg_data_bits : BitsMax;

  irc_tick_gen #(.C_DIV_W(C_DIV_W)) u_baud (
    .clk_i  (aclk),
    .rst_ni (aresetn),
    .clr_i  (hs),
    .div_i  (baud_div_q),
    .tick_o (baud_tick)
  );

  irc_tick_gen #(.C_DIV_W(C_DIV_W)) u_carrier (
    .clk_i  (aclk),
    .rst_ni (aresetn),
    .clr_i  (1'b0),
    .div_i  (cfg_carrier_div),
    .tick_o (car_tick)
  );

  // Frame sequencer: latches config at handshake and drives the registered serial line.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      bits_q     <= '0;
      bit_idx_q  <= '0;
      par_mode_q <= PAR_NONE;
      par_acc_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      car_en_q   <= 1'b0;
      baud_div_q <= '0;
      ovs_q      <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      if (!idle && baud_tick) begin
        ovs_q <= (ovs_q == OvsLast) ? '0 : (ovs_q + OvsOne);
      end
      unique case (state_q)
        StIdle: begin
          if (s_axis.tvalid) begin
            shreg_q    <= s_axis.tdata;
            bits_q     <= bits_eff;
            par_mode_q <= cfg_parity;
            stop2_q    <= cfg_stop2;
            car_en_q   <= cfg_carrier_en;
            baud_div_q <= cfg_baud_div;
            bit_idx_q  <= '0;
            par_acc_q  <= 1'b0;
            stop_idx_q <= 1'b0;
            ovs_q      <= '0;
            tx_line_q  <= 1'b0;
            state_q    <= StStart;
          end
        end
        StStart: begin
          if (bit_end) begin
            tx_line_q <= shreg_q[0];
            state_q   <= StData;
          end
        end
        StData: begin
          if (bit_end) begin
            shreg_q   <= shreg_q >> 1;
            par_acc_q <= par_acc_q ^ shreg_q[0];
            bit_idx_q <= bit_idx_q + 4'd1;
            if (bit_idx_q == bits_q - 4'd1) begin
              if (parity_en(par_mode_q)) begin
                // Parity covers the bit just sent, so fold it in before inverting for odd.
                tx_line_q <= (par_acc_q ^ shreg_q[0]) ^ (par_mode_q == PAR_ODD);
                state_q   <= StParity;
              end else begin
                tx_line_q <= 1'b1;
                state_q   <= StStop;
              end
            end else begin
              tx_line_q <= shreg_q[1];
            end
          end
        end
        StParity: begin
          if (bit_end) begin
            tx_line_q <= 1'b1;
            state_q   <= StStop;
          end
        end
        StStop: begin
          if (bit_end) begin
            if (stop2_q && !stop_idx_q) begin
              stop_idx_q <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          tx_line_q <= 1'b1;
        end
      endcase
    end
  end

  // Free-running carrier square wave; toggles once per carrier half-period.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      carrier_q <= 1'b0;
    end else if (car_tick) begin
      carrier_q <= ~carrier_q;
    end
  end

  assign s_axis.tready = idle;
  assign busy          = !idle;
  assign tx_line       = tx_line_q;
  // Carrier bursts mark the low (space) portions of the line.
  assign tx_mod        = car_en_q ? (~tx_line_q & carrier_q) : tx_line_q;

endmodule

// File: tb/tb_axis_irc_tx_gen.sv
// Scoreboard bench for axis_irc_tx_gen: driver pushes hand-computed frames, monitor checks the line.
`timescale 1ns/1ps
module tb_axis_irc_tx_gen;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] cfg_baud_div, cfg_carrier_div;
  logic [3:0]  cfg_data_bits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2, cfg_carrier_en;
  logic        busy, tx_line, tx_mod;

  always #5 aclk = ~aclk;

  axis_irc_tx_gen_if #(.C_DATA_BIT(8)) s_axis ();

  axis_irc_tx_gen #(.C_DATA_BIT(8), .C_OVERSAMPLE(16), .C_DIV_W(16)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .s_axis          (s_axis),
    .cfg_baud_div    (cfg_baud_div),
    .cfg_data_bits   (cfg_data_bits),
    .cfg_parity      (cfg_parity),
    .cfg_stop2       (cfg_stop2),
    .cfg_carrier_en  (cfg_carrier_en),
    .cfg_carrier_div (cfg_carrier_div),
    .busy            (busy),
    .tx_line         (tx_line),
    .tx_mod          (tx_mod)
  );

  typedef struct {
    int          start_cyc;
    int          nsym;
    logic [15:0] lv;     // line level per symbol, symbol 0 (start bit) in bit 0
    int          blen;
    bit          cen;
  } frame_t;

  frame_t sb_q[$];
  int     n_vec = 0;
  int     n_miss = 0;
  int     cyc = 0;
  bit     mon_en = 1'b1;
  bit     mon_busy = 1'b0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_vec++;
    if (!ok) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: on every start bit, pop the next expected frame and check it cycle by cycle.
  initial begin : monitor
    logic   prev, lvl, last;
    frame_t f;
    bit     bad_line, bad_mod, car_bad, seen;
    int     run, tog;
    prev = 1'b1;
    forever begin
      @(negedge aclk);
      if (mon_en && aresetn && prev && !tx_line) begin
        mon_busy = 1'b1;
        chk(sb_q.size() != 0, "frame_expected", sb_q.size(), 1);
        if (sb_q.size() != 0) begin
          f = sb_q.pop_front();
          chk(cyc == f.start_cyc, "start_cycle", cyc, f.start_cyc);
          for (int k = 0; k < f.nsym; k++) begin
            lvl = f.lv[k];
            bad_line = 1'b0;
            bad_mod = 1'b0;
            car_bad = 1'b0;
            seen = 1'b0;
            run = 0;
            tog = 0;
            last = 1'b0;
            for (int j = 0; j < f.blen; j++) begin
              if (k != 0 || j != 0) @(negedge aclk);
              if (tx_line !== lvl || busy !== 1'b1 || s_axis.tready !== 1'b0) bad_line = 1'b1;
              if (!f.cen && tx_mod !== lvl) bad_mod = 1'b1;
              if (f.cen && lvl && tx_mod !== 1'b0) bad_mod = 1'b1;
              if (f.cen && k == 0) begin
                if (j == 0) begin
                  last = tx_mod;
                  run = 1;
                end else if (tx_mod === last) begin
                  run++;
                end else begin
                  if (seen && run != 4) car_bad = 1'b1;
                  seen = 1'b1;
                  run = 1;
                  tog++;
                  last = tx_mod;
                end
              end
            end
            chk(!bad_line, $sformatf("line_sym%0d", k), int'(tx_line), int'(lvl));
            if (!f.cen || lvl) chk(!bad_mod, $sformatf("mod_sym%0d", k), int'(tx_mod), int'(lvl));
            if (f.cen && k == 0) chk(!car_bad && tog >= 14, "carrier_toggle", tog, 16);
          end
          @(negedge aclk);
          chk(s_axis.tready === 1'b1 && busy === 1'b0 && tx_line === 1'b1, "frame_end_idle",
              int'({s_axis.tready, busy, tx_line}), 5);
        end
        mon_busy = 1'b0;
      end
      prev = tx_line;
    end
  end

  // Driver: present one payload/config, wait for acceptance, push the expected frame.
  task automatic send(input logic [7:0] d, input int bits, input int par, input int stop2,
                      input int div, input int cen, input int cdiv, input int nsym,
                      input logic [15:0] lv, input int blen, input bit hold, input bit push);
    int     n;
    frame_t f;
    @(posedge aclk);
    #1;
    s_axis.tdata    = d;
    cfg_data_bits   = 4'(bits);
    cfg_parity      = 2'(par);
    cfg_stop2       = 1'(stop2);
    cfg_baud_div    = 16'(div);
    cfg_carrier_en  = 1'(cen);
    cfg_carrier_div = 16'(cdiv);
    s_axis.tvalid   = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!s_axis.tready && n < 5000) begin
      @(negedge aclk);
      n++;
    end
    if (!s_axis.tready) begin
      chk(s_axis.tready, "handshake_timeout", int'(s_axis.tready), 1);
      s_axis.tvalid = 1'b0;
    end else begin
      f.start_cyc = cyc + 1;
      f.nsym = nsym;
      f.lv = lv;
      f.blen = blen;
      f.cen = 1'(cen);
      if (push) sb_q.push_back(f);
      @(posedge aclk);
      #1;
      if (!hold) s_axis.tvalid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || mon_busy) && n < 20000) begin
      @(negedge aclk);
      n++;
    end
    chk(sb_q.size() == 0 && !mon_busy, name, sb_q.size(), 0);
  endtask

  initial begin : driver
    s_axis.tdata    = '0;
    s_axis.tvalid   = 1'b0;
    cfg_baud_div    = 16'd1;
    cfg_data_bits   = 4'd8;
    cfg_parity      = 2'd0;
    cfg_stop2       = 1'b0;
    cfg_carrier_en  = 1'b0;
    cfg_carrier_div = 16'd4;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk(tx_line === 1'b1, "rst_tx_line", int'(tx_line), 1);
    chk(tx_mod === 1'b1, "rst_tx_mod", int'(tx_mod), 1);
    chk(busy === 1'b0, "rst_busy", int'(busy), 0);
    chk(s_axis.tready === 1'b1, "rst_tready", int'(s_axis.tready), 1);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;

    //   data  bits par st2 div cen cdiv nsym level     blen hold push
    send(8'hA5, 8,  0,  0,  1,  0,  4,  10, 16'h034A, 16,  0,   1);  // 8N1
    send(8'hA5, 8,  1,  0,  1,  0,  4,  11, 16'h054A, 16,  0,   1);  // 8E1, parity 0
    send(8'hA5, 8,  2,  0,  1,  0,  4,  11, 16'h074A, 16,  0,   1);  // 8O1, parity 1
    send(8'h01, 12, 1,  0,  1,  0,  4,  11, 16'h0602, 16,  0,   1);  // 8E1 (12 -> 8), parity 1
    send(8'h01, 8,  2,  0,  1,  0,  4,  11, 16'h0402, 16,  0,   1);  // 8O1, parity 0
    send(8'hFF, 5,  0,  1,  3,  0,  4,  8,  16'h00FE, 48,  0,   1);  // 5N2, div 3
    send(8'hE0, 5,  0,  0,  1,  0,  4,  7,  16'h0040, 16,  0,   1);  // upper bits dropped

    // Config change during DATA must not disturb the running frame.
    send(8'h3C, 8,  0,  0,  2,  0,  4,  10, 16'h0278, 32,  0,   1);
    repeat (100) @(posedge aclk);
    #1;
    cfg_baud_div = 16'd7;
    cfg_parity   = 2'd1;
    send(8'h3C, 8,  1,  0,  7,  0,  4,  11, 16'h0478, 112, 0,   1);

    // Carrier on, then off again.
    send(8'h00, 8,  0,  0,  4,  1,  4,  10, 16'h0200, 64,  0,   1);
    send(8'hA5, 8,  0,  0,  1,  0,  4,  10, 16'h034A, 16,  0,   1);

    // Back-to-back with tvalid held and divisor 0.
    send(8'h55, 8,  0,  0,  0,  0,  4,  10, 16'h02AA, 16,  1,   1);
    send(8'h0F, 8,  0,  0,  0,  0,  4,  10, 16'h021E, 16,  1,   1);
    send(8'hF0, 8,  0,  0,  0,  0,  4,  10, 16'h03E0, 16,  0,   1);
    drain("drain_before_reset");

    // Reset in the middle of DATA.
    mon_en = 1'b0;
    send(8'h00, 8,  0,  0,  1,  1,  4,  10, 16'h0200, 16,  0,   0);
    repeat (40) @(posedge aclk);
    @(negedge aclk);
    chk(busy === 1'b1, "busy_before_reset", int'(busy), 1);
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    chk(tx_line === 1'b1, "abort_tx_line", int'(tx_line), 1);
    chk(busy === 1'b0, "abort_busy", int'(busy), 0);
    chk(s_axis.tready === 1'b1, "abort_tready", int'(s_axis.tready), 1);
    chk(tx_mod === 1'b1, "abort_tx_mod", int'(tx_mod), 1);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    mon_en = 1'b1;

    send(8'hA5, 8,  0,  0,  1,  0,  4,  10, 16'h034A, 16,  0,   1);
    drain("drain_final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/axis_irc_tx_gen.md
# axis_irc_tx_gen

Parametrised IR serial transmitter with an AXI4-Stream byte input. It generalises the fixed-format IR UART transmitter with runtime-selectable data length, parity, stop-bit count, baud divisor and carrier divisor. Each frame's configuration is latched at frame acceptance. It sits between the framing/DMA stream and the IR LED driver. It outputs both the raw serial line and the carrier-modulated line.

## Interface
Parameters:
- C_DATA_BIT, 8: maximum data bits per frame (5..9); also the width of s_axis_tdata.
- C_OVERSAMPLE, 16: baud ticks per bit (2..64).
- C_DIV_W, 16: width of the baud and carrier divisor inputs.

Ports:
- aclk  in  1  sole clock.
- aresetn  in  1  synchronous active-low reset.
- s_axis_tready  out  1  high exactly when the FSM is in IDLE.
- s_axis_tdata  in  C_DATA_BIT  frame payload, sent LSB first.
- s_axis_tvalid  in  1  payload valid.
- cfg_baud_div  in  C_DIV_W  aclk cycles per baud tick; 0 is treated as 1.
- cfg_data_bits  in  4  data bits per frame; values outside 5..C_DATA_BIT are treated as C_DATA_BIT.
- cfg_parity  in  2  parity mode: 0 none, 1 even, 2 odd, 3 none.
- cfg_stop2  in  1  0 selects 1 stop bit, 1 selects 2 stop bits.
- cfg_carrier_en  in  1  enables carrier modulation on tx_mod.
- cfg_carrier_div  in  C_DIV_W  aclk cycles per carrier half-period; 0 is treated as 1.
- busy  out  1  high when state is not IDLE.
- tx_line  out  1  raw serial line (registered; idle high).
- tx_mod  out  1  modulated output.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Handshake: a transfer occurs when s_axis_tvalid is high in IDLE. On that cycle the block latches tdata, all cfg_* inputs, and the effective bit count. It then moves to START. cfg_* changes mid-frame have no effect.
- IDLE: tx_line is 1.
- START: tx_line is 0 for one bit time, then DATA with bit index 0.
- DATA: tx_line equals the shift register LSB. At each bit end the register shifts right. After bit index (bits−1), the FSM moves to PARITY if parity is enabled, otherwise to STOP.
- Data bits above the latched bit count are ignored.
- PARITY: tx_line is the XOR of the transmitted data bits (even mode), or its inverse (odd mode). It lasts one bit time, then the FSM moves to STOP.
- STOP: tx_line is 1 for 1 or 2 bit times, then IDLE.
- Bit time: C_OVERSAMPLE baud ticks, i.e. exactly C_OVERSAMPLE×max(div,1) cycles.
- Baud divider: cleared on handshake. It ticks on the cycle its count reaches div−1, then wraps to 0.
- Carrier: a free-running divider that toggles the carrier register when its count reaches div−1. Both the carrier register and its count reset to 0.
- Output mapping: tx_mod = cfg_carrier_en_latched ? (~tx_line & carrier) : tx_line. The latched enable is cfg_carrier_en sampled at the last handshake (0 after reset).

## Timing
- Reset values: tx_line 1, carrier 0, tx_mod 1, busy 0, s_axis_tready 1 (combinational from state), state IDLE, all counters 0.
- Reset mid-frame aborts the frame immediately and returns all outputs to their reset values on the next edge.
- Latency: with the handshake at cycle T, tx_line falls at T+1.
- Each bit lasts B = C_OVERSAMPLE×div cycles.
- Frame length: F = (1 + bits + parity + stops)×B.
- IDLE (tready=1) is reached at T+1+F.
- Back-to-back frames: a second handshake at T+1+F gives a start bit at T+2+F. The line therefore idles for at least one cycle beyond the stop bits.
- tvalid may drop without transfer while tready is high. No state change occurs.

## Structure
- Package irc_pkg holds:
  - the state enum;
  - parity codes PAR_NONE, PAR_EVEN, PAR_ODD;
  - the min/max data-bit constants.
- One sub-module, irc_tick_gen: a C_DIV_W reloadable divider with synchronous clear. It outputs a one-cycle tick and treats div 0 as 1.
  - It is instantiated twice: once for baud (cleared on handshake) and once for the carrier (never cleared; it drives the toggle register).

## Test plan
- Basic 8N1: div=1, OVS=16, 8N1, tdata 0xA5.
  - tx_line holds 0,1,0,1,0,0,1,0,1,1, 16 cycles each, starting at T+1.
  - tready reappears at T+161.
- Parity modes: 8E1 and 8O1 with 0xA5, then 0x01.
  - Parity bits are 0, 1, 1, 0 respectively.
  - Frames are 176 cycles long.
- Length and stop bits: 5 bits, 2 stop bits, tdata 0xFF, div=3.
  - Line shows start, five 1s, two stop 1s; 48 cycles per bit; tready at T+1+384.
  - Upper data bits never appear on the line.
- Config change mid-frame: change cfg_baud_div from 2 to 7 and cfg_parity during DATA.
  - The current frame keeps div 2 with no parity.
  - The next frame uses the new values.
- Carrier: cfg_carrier_en=1, carrier_div=4.
  - During the start bit, tx_mod toggles every 4 cycles.
  - tx_mod stays 0 while tx_line is 1.
  - With cfg_carrier_en=0, tx_mod equals tx_line exactly.
- Reset and back-to-back: tvalid held high continuously with div=0 (treated as 1).
  - Consecutive start bits are separated by exactly one idle-high cycle after the stop bits.
  - aresetn low mid-DATA gives tx_line=1, busy=0 on the next edge.
